// File: rtl/operand_fetch_ctrl_pkg.sv
// Shared definitions for the operand fetch controller: FSM state encoding,
// instruction field positions and default operand/address widths.
package operand_fetch_ctrl_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 4;
    localparam int INSTR_W    = 16;

    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 12;
    localparam int A1_MSB   = 11;
    localparam int A1_LSB   = 8;
    localparam int A2_MSB   = 7;
    localparam int A2_LSB   = 4;
    localparam int DEST_MSB = 3;
    localparam int DEST_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_CAPT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/operand_fetch_ctrl.sv
// Operand fetch controller: decodes an instruction, reads two registered operand
// memories and presents a stable bundle to the ALU. OPFETCH_OVERLAP_EN lets the
// next fetch run while a bundle is still waiting for out_ready.
//
// state | meaning
// IDLE  | ready for an instruction; latches addresses and opcode/dest on accept
// WAIT  | memories register the new addresses
// CAPT  | memory data valid; loads output buffer once it is free
// HOLD  | bundle presented until out_ready (not used with overlap enabled)
module operand_fetch_ctrl
    import operand_fetch_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    output logic [ADDR_W-1:0] operand1_addr,
    output logic [ADDR_W-1:0] operand2_addr,
    input  logic [DATA_W-1:0] operand1_value,
    input  logic [DATA_W-1:0] operand2_value,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_opcode,
    output logic [3:0]        out_dest,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2
);

    fetch_state_t state;
    fetch_state_t state_next;

    logic [3:0] hold_opcode;
    logic [3:0] hold_dest;
    logic       accept;
    logic       capture;

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                state_next = ST_CAPT;
            end
            ST_CAPT: begin
                // Buffer is free when empty or when its bundle retires this edge.
                if (!out_valid || out_ready) begin
                    capture = 1'b1;
`ifdef OPFETCH_OVERLAP_EN
                    state_next = ST_IDLE;
`else
                    state_next = ST_HOLD;
`endif
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            operand1_addr <= '0;
            operand2_addr <= '0;
            hold_opcode   <= '0;
            hold_dest     <= '0;
            out_valid     <= 1'b0;
            out_opcode    <= '0;
            out_dest      <= '0;
            out_op1       <= '0;
            out_op2       <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                operand1_addr <= ADDR_W'(in_instr[A1_MSB:A1_LSB]);
                operand2_addr <= ADDR_W'(in_instr[A2_MSB:A2_LSB]);
                hold_opcode   <= in_instr[OPC_MSB:OPC_LSB];
                hold_dest     <= in_instr[DEST_MSB:DEST_LSB];
            end
            if (capture) begin
                out_valid  <= 1'b1;
                out_opcode <= hold_opcode;
                out_dest   <= hold_dest;
                out_op1    <= operand1_value;
                out_op2    <= operand2_value;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
